mode_sequencer: RTL and testbench

//  Parametrised top-level mode controller for the smart environment controller; succeeds the fixed 3-mode selector.

---
 rtl/mode_sequencer.sv | 148 ++++++++++++++
 tb/tb_mode_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Top-level mode controller: steps through NUM_MODES modes on switch+L/R, saves and
// restores per-mode sub-FSM state, returns home after inactivity and freezes under a lock.
module mode_sequencer #(
  parameter int NUM_MODES    = 3,
  parameter int SUB_W        = 3,
  parameter int HOME_MODE    = 0,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int RESUME_EN    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode_change_sw,
  input  logic [4:0]                 rise_button,
  input  logic                       lock_req,
  input  logic [SUB_W-1:0]           sub_state_in,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic [NUM_MODES-1:0]       mode_onehot,
  output logic                       mode_exit,
  output logic                       mode_enter,
  output logic [SUB_W-1:0]           restore_state,
  output logic                       locked,
  output logic                       busy
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int CNT_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [MODE_W-1:0] HOME    = MODE_W'(HOME_MODE);
  localparam logic [MODE_W-1:0] LAST    = MODE_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_EXIT,
    ST_ENTER,
    ST_LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [MODE_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUB_W-1:0]    ctx_q [NUM_MODES];
  logic [SUB_W-1:0]    ctx_d [NUM_MODES];
  logic [NUM_MODES-1:0] onehot_q, onehot_d;
  logic                exit_q, exit_d;
  logic                enter_q, enter_d;
  logic [SUB_W-1:0]    restore_q, restore_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic                timeout_hit;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    ctx_d     = ctx_q;
    restore_d = restore_q;

    timeout_hit = (IDLE_TIMEOUT != 0) && (cnt_q == CNT_MAX) && (mode_q != HOME);

    case (state_q)
      ST_RUN: begin
        cnt_d = (|rise_button) ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        if (lock_req) begin
          state_d = ST_LOCK;
        end else if (mode_change_sw && rise_button[2]) begin
          target_d = (mode_q == LAST) ? '0 : mode_q + MODE_W'(1);
          state_d  = ST_EXIT;
        end else if (mode_change_sw && rise_button[1]) begin
          target_d = (mode_q == '0) ? LAST : mode_q - MODE_W'(1);
          state_d  = ST_EXIT;
        end else if (timeout_hit) begin
          target_d = HOME;
          state_d  = ST_EXIT;
        end
      end
      ST_EXIT: begin
        cnt_d         = '0;
        ctx_d[mode_q] = sub_state_in;
        mode_d        = target_q;
        state_d       = ST_ENTER;
      end
      ST_ENTER: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_LOCK: begin
        cnt_d = '0;
        if (!lock_req) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // The target never equals the outgoing mode, so ctx_q already holds the value to restore.
    if (state_d == ST_ENTER) begin
      restore_d = (RESUME_EN != 0) ? ctx_q[target_q] : '0;
    end

    exit_d   = (state_d == ST_EXIT);
    enter_d  = (state_d == ST_ENTER);
    locked_d = (state_d == ST_LOCK);
    busy_d   = (state_d == ST_EXIT) || (state_d == ST_ENTER);

    onehot_d         = '0;
    onehot_d[mode_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      mode_q    <= HOME;
      target_q  <= HOME;
      cnt_q     <= '0;
      ctx_q     <= '{default: '0};
      onehot_q  <= NUM_MODES'(1) << HOME_MODE;
      exit_q    <= 1'b0;
      enter_q   <= 1'b0;
      restore_q <= '0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      ctx_q     <= ctx_d;
      onehot_q  <= onehot_d;
      exit_q    <= exit_d;
      enter_q   <= enter_d;
      restore_q <= restore_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
    end
  end

  assign mode          = mode_q;
  assign mode_onehot   = onehot_q;
  assign mode_exit     = exit_q;
  assign mode_enter    = enter_q;
  assign restore_state = restore_q;
  assign locked        = locked_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: a schedule-based reference model predicts each cycle's
// outputs, a monitor pops and compares; a second instance runs with resume disabled.
module tb_mode_sequencer;

  localparam int N    = 3;
  localparam int SW   = 3;
  localparam int HOME = 0;
  localparam int T    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode_change_sw = 1'b0;
  logic [4:0]    rise_button = '0;
  logic          lock_req = 1'b0;
  logic [SW-1:0] sub_state_in = '0;

  logic [1:0]    mode, mode_nr;
  logic [N-1:0]  mode_onehot, mode_onehot_nr;
  logic          mode_exit, mode_exit_nr;
  logic          mode_enter, mode_enter_nr;
  logic [SW-1:0] restore_state, restore_state_nr;
  logic          locked, locked_nr;
  logic          busy, busy_nr;

  mode_sequencer #(.NUM_MODES(N), .SUB_W(SW), .HOME_MODE(HOME), .IDLE_TIMEOUT(T), .RESUME_EN(1)) dut (
    .clk(clk), .reset(reset), .mode_change_sw(mode_change_sw), .rise_button(rise_button),
    .lock_req(lock_req), .sub_state_in(sub_state_in), .mode(mode), .mode_onehot(mode_onehot),
    .mode_exit(mode_exit), .mode_enter(mode_enter), .restore_state(restore_state),
    .locked(locked), .busy(busy)
  );

  mode_sequencer #(.NUM_MODES(N), .SUB_W(SW), .HOME_MODE(HOME), .IDLE_TIMEOUT(T), .RESUME_EN(0)) dut_nr (
    .clk(clk), .reset(reset), .mode_change_sw(mode_change_sw), .rise_button(rise_button),
    .lock_req(lock_req), .sub_state_in(sub_state_in), .mode(mode_nr), .mode_onehot(mode_onehot_nr),
    .mode_exit(mode_exit_nr), .mode_enter(mode_enter_nr), .restore_state(restore_state_nr),
    .locked(locked_nr), .busy(busy_nr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int mode;
    bit ex;
    bit en;
    int restore;
    bit lk;
    bit bz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a mode switch is a scheduled two-cycle event (exit, then enter).
  int   m_mode = HOME;
  int   m_target = HOME;
  int   m_age = 0;
  bit   m_locked = 1'b0;
  int   m_idle = 0;
  int   saved [N];

  bit            d_sw = 1'b1;
  bit            d_lk = 1'b0;
  logic [SW-1:0] d_sub = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rst, input bit sw, input logic [4:0] btn,
                                input bit lk, input logic [SW-1:0] sub);
    exp_t e;
    reset          = rst;
    mode_change_sw = sw;
    rise_button    = btn;
    lock_req       = lk;
    sub_state_in   = sub;

    if (rst) begin
      m_mode = HOME; m_age = 0; m_locked = 1'b0; m_idle = 0;
      for (int i = 0; i < N; i++) saved[i] = 0;
    end else if (m_age == 1) begin
      saved[m_mode] = int'(sub);
      m_mode = m_target; m_age = 2; m_idle = 0;
    end else if (m_age == 2) begin
      m_age = 0; m_idle = 0;
    end else if (m_locked) begin
      m_idle = 0;
      if (!lk) m_locked = 1'b0;
    end else if (lk) begin
      m_locked = 1'b1; m_idle = 0;
    end else if (sw && btn[2]) begin
      m_target = (m_mode + 1) % N; m_age = 1;
    end else if (sw && btn[1]) begin
      m_target = (m_mode + N - 1) % N; m_age = 1;
    end else if (m_idle == T && m_mode != HOME) begin
      m_target = HOME; m_age = 1;
    end else begin
      m_idle = (btn != 0) ? 0 : ((m_idle < T) ? m_idle + 1 : T);
    end

    e.cyc     = cyc + 1;
    e.mode    = m_mode;
    e.ex      = (m_age == 1);
    e.en      = (m_age == 2);
    e.restore = saved[m_mode];
    e.lk      = m_locked;
    e.bz      = (m_age != 0);
    sb.push_back(e);

    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input logic [4:0] first_btn, input int n);
    apply_stimulus(1'b0, d_sw, first_btn, d_lk, d_sub);
    for (int i = 1; i < n; i++) apply_stimulus(1'b0, d_sw, 5'b0, d_lk, d_sub);
  endtask

  exp_t mon_e;

  // Monitor: every cycle that has a prediction is compared against both instances.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check_output("sb_cycle", cyc, mon_e.cyc);
      check_output("mode", mode, mon_e.mode);
      check_output("mode_onehot", mode_onehot, 1 << mon_e.mode);
      check_output("mode_exit", mode_exit, mon_e.ex);
      check_output("mode_enter", mode_enter, mon_e.en);
      check_output("locked", locked, mon_e.lk);
      check_output("busy", busy, mon_e.bz);
      if (mon_e.en) check_output("restore_state", restore_state, mon_e.restore);
      check_output("nr_mode", mode_nr, mon_e.mode);
      check_output("nr_mode_enter", mode_enter_nr, mon_e.en);
      if (mon_e.en) check_output("nr_restore_state", restore_state_nr, 0);
    end
  end

  initial begin
    int dens;
    bit r_lk;
    logic [4:0] r_btn;

    @(posedge clk);
    #1;
    repeat (3) apply_stimulus(1'b1, 1'b0, 5'b0, 1'b0, '0);

    d_sw = 1'b1; d_sub = 3'd1;
    repeat (3) run_cycles(5'b00100, 4);
    run_cycles(5'b00010, 4);
    run_cycles(5'b00100, 4);
    run_cycles(5'b00100, 4);
    run_cycles(5'b00110, 4);

    run_cycles(5'b00010, 4);
    d_sub = 3'd5;
    run_cycles(5'b00100, 4);
    d_sub = 3'd3;
    run_cycles(5'b00010, 4);

    run_cycles(5'b00100, 7);
    run_cycles(5'b10000, 14);
    run_cycles(5'b00100, 4);
    run_cycles(5'b0, 14);

    d_lk = 1'b1;
    run_cycles(5'b0, 2);
    run_cycles(5'b00100, 3);
    d_lk = 1'b0;
    run_cycles(5'b0, 2);
    run_cycles(5'b00100, 4);
    run_cycles(5'b00100, 1);
    d_lk = 1'b1;
    run_cycles(5'b0, 5);
    d_lk = 1'b0;
    run_cycles(5'b0, 2);

    run_cycles(5'b00100, 1);
    apply_stimulus(1'b1, 1'b1, 5'b0, 1'b0, 3'd6);
    run_cycles(5'b0, 3);
    run_cycles(5'b00010, 4);

    r_lk = 1'b0;
    dens = 6;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = $urandom_range(3, 30);
      if ($urandom_range(0, 39) == 0) r_lk = ~r_lk;
      r_btn = ($urandom_range(0, dens - 1) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, r_btn, r_lk,
                     3'($urandom_range(0, 7)));
    end

    apply_stimulus(1'b0, 1'b0, 5'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_output("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
